// File: rtl/decode_stage_pipe.sv
// rtl/decode_stage_pipe.sv - elastic decode stage with 2-entry skid buffer between fetch and execute
//
// Purpose:
//   Splits an instruction word into opcode, destination/source register indices,
//   an extended immediate and a src2-select bit. The decoded bundle is registered
//   in a main slot (M) that drives the outputs. A second skid slot (S) lets fetch
//   complete one more transfer while execute stalls. Outputs are driven only from
//   registers.
//
// Optional feature:
//   Define DECODE_ILLEGAL_CHECK_EN to add parameter NUM_OPS. Any opcode >= NUM_OPS
//   is still forwarded, but it carries oILLEGAL=1. Without the macro, oILLEGAL is 0.
//
// Ports:
//   iCLK                 clock, rising edge
//   iRST                 asynchronous active-low reset
//   iVALID / oREADY      upstream handshake; oREADY is high when the skid slot is empty
//   iINSTRUCTION         instruction word [INSN_W]
//   iFLUSH               drops both buffered bundles at the next edge
//   oVALID / iREADY      downstream handshake
//   oEXE_OP              opcode [OP_W]
//   oIN1_IDX, oIN2_IDX   source register indices [IDX_W]
//   oDST_IDX             destination register index [IDX_W]
//   oIMM_VAL             zero- or sign-extended immediate [DATA_W]
//   oSRC2_IS_REG_OR_IMM  1 = src2 is the immediate, 0 = src2 is the register
//   oDEC_CNT             bundles handed downstream, wraps [CNT_W]
//   oILLEGAL             opcode out of range (only with DECODE_ILLEGAL_CHECK_EN)

module decode_stage_pipe #(
    parameter int INSN_W   = 16,
    parameter int OP_W     = 4,
    parameter int IDX_W    = 2,
    parameter int IMM_W    = 8,
    parameter int DATA_W   = 8,
    parameter int IMM_SEXT = 0,
    parameter int CNT_W    = 16
`ifdef DECODE_ILLEGAL_CHECK_EN
    ,
    parameter int NUM_OPS  = 12
`endif
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iVALID,
    output logic              oREADY,
    input  logic [INSN_W-1:0] iINSTRUCTION,
    input  logic              iFLUSH,
    output logic              oVALID,
    input  logic              iREADY,
    output logic [OP_W-1:0]   oEXE_OP,
    output logic [IDX_W-1:0]  oIN1_IDX,
    output logic [IDX_W-1:0]  oIN2_IDX,
    output logic [IDX_W-1:0]  oDST_IDX,
    output logic [DATA_W-1:0] oIMM_VAL,
    output logic              oSRC2_IS_REG_OR_IMM,
    output logic [CNT_W-1:0]  oDEC_CNT,
    output logic              oILLEGAL
);

    // The register index fields sit directly below the opcode, one after another.
    localparam int OP_HI  = INSN_W - 1;
    localparam int DST_HI = OP_HI - OP_W;
    localparam int IN1_HI = DST_HI - IDX_W;
    localparam int IN2_HI = IN1_HI - IDX_W;

    typedef struct packed {
        logic              illegal;
        logic              src2_imm;
        logic [DATA_W-1:0] imm;
        logic [IDX_W-1:0]  in2;
        logic [IDX_W-1:0]  in1;
        logic [IDX_W-1:0]  dst;
        logic [OP_W-1:0]   op;
    } bundle_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    bundle_t           dec_bundle;
    bundle_t           m_q;
    bundle_t           s_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [IMM_W-1:0]  imm_raw;
    logic [DATA_W-1:0] imm_ext;
    logic              in_xfer;
    logic              out_xfer;
    logic              load_m_in;
    logic              load_m_skid;
    logic              load_s;

    // ------------------------------------------------------------------
    // Combinational decode of the incoming word
    // ------------------------------------------------------------------
    assign imm_raw = iINSTRUCTION[IMM_W-1:0];

    generate
        if (DATA_W > IMM_W) begin : g_imm_extend
            logic ext_bit;
            assign ext_bit = (IMM_SEXT != 0) ? imm_raw[IMM_W-1] : 1'b0;
            assign imm_ext = {{(DATA_W-IMM_W){ext_bit}}, imm_raw};
        end else begin : g_imm_pass
            assign imm_ext = imm_raw;
        end
    endgenerate

`ifdef DECODE_ILLEGAL_CHECK_EN
    // One extra bit lets NUM_OPS == 2**OP_W mean "every opcode is legal".
    localparam logic [OP_W:0] NUM_OPS_V = (OP_W+1)'(NUM_OPS);
    logic dec_illegal;
    assign dec_illegal = ({1'b0, iINSTRUCTION[OP_HI -: OP_W]} >= NUM_OPS_V);
`else
    logic dec_illegal;
    assign dec_illegal = 1'b0;
`endif

    always_comb begin
        dec_bundle          = '0;
        dec_bundle.op       = iINSTRUCTION[OP_HI  -: OP_W];
        dec_bundle.dst      = iINSTRUCTION[DST_HI -: IDX_W];
        dec_bundle.in1      = iINSTRUCTION[IN1_HI -: IDX_W];
        dec_bundle.in2      = iINSTRUCTION[IN2_HI -: IDX_W];
        dec_bundle.imm      = imm_ext;
        dec_bundle.src2_imm = iINSTRUCTION[OP_HI];
        dec_bundle.illegal  = dec_illegal;
    end

    // ------------------------------------------------------------------
    // Handshakes. Ready and valid both come from the registered state only.
    // ------------------------------------------------------------------
    assign oREADY   = (state_q != ST_FULL);
    assign oVALID   = (state_q != ST_EMPTY);
    assign in_xfer  = iVALID && oREADY;
    assign out_xfer = oVALID && iREADY;

    // ------------------------------------------------------------------
    // Occupancy FSM
    // ------------------------------------------------------------------
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        load_m_in   = 1'b0;
        load_m_skid = 1'b0;
        load_s      = 1'b0;
        if (iFLUSH) begin
            // A flush overrides any input transfer in the same cycle.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        load_m_in = 1'b1;
                        state_d   = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (in_xfer && out_xfer) begin
                        load_m_in = 1'b1;
                    end else if (out_xfer) begin
                        state_d = ST_EMPTY;
                    end else if (in_xfer) begin
                        // Downstream stalled, so the new word goes to the skid slot.
                        load_s  = 1'b1;
                        state_d = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (out_xfer) begin
                        load_m_skid = 1'b1;
                        state_d     = ST_BUSY;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Bundle storage. Slot contents persist while the slot is invalid, so the
    // outputs keep their last value. The only exception is the illegal flag,
    // which a flush clears.
    // ------------------------------------------------------------------
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            m_q <= '0;
            s_q <= '0;
        end else if (iFLUSH) begin
            m_q.illegal <= 1'b0;
            s_q.illegal <= 1'b0;
        end else begin
            if (load_m_in) begin
                m_q <= dec_bundle;
            end else if (load_m_skid) begin
                m_q <= s_q;
            end
            if (load_s) begin
                s_q <= dec_bundle;
            end
        end
    end

    // Any output transfer is counted, including one in a flush cycle.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            cnt_q <= '0;
        end else if (out_xfer) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign oEXE_OP             = m_q.op;
    assign oDST_IDX            = m_q.dst;
    assign oIN1_IDX            = m_q.in1;
    assign oIN2_IDX            = m_q.in2;
    assign oIMM_VAL            = m_q.imm;
    assign oSRC2_IS_REG_OR_IMM = m_q.src2_imm;
    assign oILLEGAL            = m_q.illegal;
    assign oDEC_CNT            = cnt_q;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// tb/tb_decode_stage_pipe.sv - scoreboard bench for decode_stage_pipe
module tb_decode_stage_pipe;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iVALID;
    logic        iFLUSH;
    logic        iREADY;
    logic [15:0] iINSTRUCTION;

    logic        oREADY, oVALID, oSRC2_IS_REG_OR_IMM, oILLEGAL;
    logic [3:0]  oEXE_OP;
    logic [1:0]  oIN1_IDX, oIN2_IDX, oDST_IDX;
    logic [7:0]  oIMM_VAL;
    logic [15:0] oDEC_CNT;

    logic        s_ready, s_valid, s_src2, s_ill;
    logic [3:0]  s_op;
    logic [1:0]  s_in1, s_in2, s_dst;
    logic [7:0]  s_imm;
    logic [15:0] s_cnt;

    logic        z_ready, z_valid, z_src2, z_ill;
    logic [3:0]  z_op;
    logic [1:0]  z_in1, z_in2, z_dst;
    logic [7:0]  z_imm;
    logic [3:0]  z_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] sb[$];
    logic [31:0] exp_cnt = 0;
    logic [15:0] saved_cnt;

    always #5 iCLK = ~iCLK;

    decode_stage_pipe u_dut (
        .iCLK(iCLK), .iRST(iRST), .iVALID(iVALID), .oREADY(oREADY),
        .iINSTRUCTION(iINSTRUCTION), .iFLUSH(iFLUSH), .oVALID(oVALID), .iREADY(iREADY),
        .oEXE_OP(oEXE_OP), .oIN1_IDX(oIN1_IDX), .oIN2_IDX(oIN2_IDX), .oDST_IDX(oDST_IDX),
        .oIMM_VAL(oIMM_VAL), .oSRC2_IS_REG_OR_IMM(oSRC2_IS_REG_OR_IMM),
        .oDEC_CNT(oDEC_CNT), .oILLEGAL(oILLEGAL)
    );

    decode_stage_pipe #(.IMM_W(4), .DATA_W(8), .IMM_SEXT(1)) u_sext (
        .iCLK(iCLK), .iRST(iRST), .iVALID(iVALID), .oREADY(s_ready),
        .iINSTRUCTION(iINSTRUCTION), .iFLUSH(iFLUSH), .oVALID(s_valid), .iREADY(iREADY),
        .oEXE_OP(s_op), .oIN1_IDX(s_in1), .oIN2_IDX(s_in2), .oDST_IDX(s_dst),
        .oIMM_VAL(s_imm), .oSRC2_IS_REG_OR_IMM(s_src2),
        .oDEC_CNT(s_cnt), .oILLEGAL(s_ill)
    );

    decode_stage_pipe #(.IMM_W(4), .DATA_W(8), .IMM_SEXT(0), .CNT_W(4)) u_zext (
        .iCLK(iCLK), .iRST(iRST), .iVALID(iVALID), .oREADY(z_ready),
        .iINSTRUCTION(iINSTRUCTION), .iFLUSH(iFLUSH), .oVALID(z_valid), .iREADY(iREADY),
        .oEXE_OP(z_op), .oIN1_IDX(z_in1), .oIN2_IDX(z_in2), .oDST_IDX(z_dst),
        .oIMM_VAL(z_imm), .oSRC2_IS_REG_OR_IMM(z_src2),
        .oDEC_CNT(z_cnt), .oILLEGAL(z_ill)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_ill(input logic [15:0] w);
`ifdef DECODE_ILLEGAL_CHECK_EN
        return (w[15:12] >= 4'd12);
`else
        return 1'b0;
`endif
    endfunction

    // Scoreboard monitor. The queue holds the accepted, not-yet-delivered words
    // in order. Its depth sets the expected valid and ready.
    always @(negedge iCLK) begin
        if (iRST) begin
            logic        can_accept;
            logic [15:0] w;
            can_accept = (sb.size() < 2);
            check("valid", oVALID, sb.size() > 0);
            check("ready", oREADY, can_accept);
            check("sext_valid", s_valid, sb.size() > 0);
            check("zext_ready", z_ready, can_accept);
            check("cnt", oDEC_CNT, exp_cnt[15:0]);
            check("cnt4", z_cnt, exp_cnt[3:0]);
            if (oVALID && iREADY) begin
                if (sb.size() == 0) begin
                    check("underflow", 1, 0);
                end else begin
                    w = sb.pop_front();
                    check("op",   oEXE_OP, w[15:12]);
                    check("dst",  oDST_IDX, w[11:10]);
                    check("in1",  oIN1_IDX, w[9:8]);
                    check("in2",  oIN2_IDX, w[7:6]);
                    check("imm",  oIMM_VAL, w[7:0]);
                    check("src2", oSRC2_IS_REG_OR_IMM, w[15]);
                    check("ill",  oILLEGAL, exp_ill(w));
                    check("imm_sext", s_imm, {{4{w[3]}}, w[3:0]});
                    check("imm_zext", z_imm, {4'h0, w[3:0]});
                end
                exp_cnt++;
            end
            if (iFLUSH) sb.delete();
            else if (iVALID && can_accept) sb.push_back(iINSTRUCTION);
        end
    end

    task automatic send(input logic [15:0] w);
        bit done;
        done = 0;
        iVALID = 1'b1;
        iINSTRUCTION = w;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge iCLK);
            done = oREADY && !iFLUSH;
            @(posedge iCLK);
            #1;
        end
        if (!done) check("send_timeout", 0, 1);
        iVALID = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        iRST = 1'b0; iVALID = 1'b0; iFLUSH = 1'b0; iREADY = 1'b0; iINSTRUCTION = '0;
        repeat (2) @(posedge iCLK);
        #1;
        check("rst_valid", oVALID, 0);
        check("rst_op", oEXE_OP, 0);
        check("rst_imm", oIMM_VAL, 0);
        check("rst_cnt", oDEC_CNT, 0);
        check("rst_ill", oILLEGAL, 0);
        iRST = 1'b1;
        @(negedge iCLK);
        check("rst_ready", oREADY, 1);
        @(posedge iCLK);
        #1;

        // Single transfer of A5C3
        iREADY = 1'b1;
        send(16'hA5C3);
        @(negedge iCLK);
        check("t1_valid", oVALID, 1);
        check("t1_op", oEXE_OP, 4'hA);
        check("t1_dst", oDST_IDX, 1);
        check("t1_in1", oIN1_IDX, 1);
        check("t1_in2", oIN2_IDX, 3);
        check("t1_imm", oIMM_VAL, 8'hC3);
        check("t1_src2", oSRC2_IS_REG_OR_IMM, 1);
        @(posedge iCLK);
        #1;
        @(negedge iCLK);
        check("t1_cnt", oDEC_CNT, 1);
        @(posedge iCLK);
        #1;

        // Back-pressure: the third word is held upstream until the skid slot drains
        iREADY = 1'b0;
        send(16'h1000);
        send(16'h2000);
        iVALID = 1'b1;
        iINSTRUCTION = 16'h3000;
        repeat (3) begin
            @(negedge iCLK);
            check("bp_ready", oREADY, 0);
            check("bp_hold_op", oEXE_OP, 1);
            @(posedge iCLK);
            #1;
        end
        iREADY = 1'b1;
        @(negedge iCLK);
        check("bp_out1", {oVALID, oEXE_OP}, 5'h11);
        @(posedge iCLK);
        #1;
        @(negedge iCLK);
        check("bp_out2", {oVALID, oEXE_OP}, 5'h12);
        @(posedge iCLK);
        #1;
        iVALID = 1'b0;
        @(negedge iCLK);
        check("bp_out3", {oVALID, oEXE_OP}, 5'h13);
        @(posedge iCLK);
        #1;

        // Flush while FULL with a same-cycle input
        iREADY = 1'b0;
        send(16'hE111);
        send(16'hD122);
        iVALID = 1'b1;
        iINSTRUCTION = 16'h7000;
        iFLUSH = 1'b1;
        saved_cnt = oDEC_CNT;
        @(posedge iCLK);
        #1;
        iFLUSH = 1'b0;
        iVALID = 1'b0;
        @(negedge iCLK);
        check("fl_valid", oVALID, 0);
        check("fl_ready", oREADY, 1);
        check("fl_cnt", oDEC_CNT, saved_cnt);
        check("fl_ill", oILLEGAL, 0);
        iREADY = 1'b1;
        repeat (3) @(posedge iCLK);
        #1;

        // Asynchronous reset mid-cycle while FULL
        iREADY = 1'b0;
        send(16'h1234);
        send(16'h2345);
        @(posedge iCLK);
        #2;
        iRST = 1'b0;
        sb.delete();
        exp_cnt = 0;
        #1;
        check("ar_valid", oVALID, 0);
        check("ar_op", oEXE_OP, 0);
        check("ar_dst", oDST_IDX, 0);
        check("ar_imm", oIMM_VAL, 0);
        check("ar_cnt", oDEC_CNT, 0);
        check("ar_cnt4", z_cnt, 0);
        check("ar_ill", oILLEGAL, 0);
        @(posedge iCLK);
        @(posedge iCLK);
        #1;
        iRST = 1'b1;

        // One-cycle latency after release, and immediate extension
        iREADY = 1'b1;
        send(16'h123A);
        @(negedge iCLK);
        check("lat_valid", oVALID, 1);
        check("lat_op", oEXE_OP, 1);
        check("sext_fa", s_imm, 8'hFA);
        check("zext_0a", z_imm, 8'h0A);
        @(posedge iCLK);
        #1;

        // Sixteen more transfers wrap the 4-bit counter to 1
        for (int i = 0; i < 16; i++) begin
            if (i == 3)      send(16'hD03A);
            else if (i == 4) send(16'h3005);
            else             send(16'($urandom));
        end
        @(posedge iCLK);
        #1;
        @(negedge iCLK);
        check("wrap_cnt4", z_cnt, 1);
        check("wrap_cnt", oDEC_CNT, 17);
        @(posedge iCLK);
        #1;

        // Random traffic with stalls and occasional flushes
        repeat (300) begin
            iVALID = 1'($urandom % 2);
            iREADY = ($urandom % 4) != 0;
            iFLUSH = ($urandom % 16) == 0;
            iINSTRUCTION = 16'($urandom);
            @(posedge iCLK);
            #1;
        end
        iVALID = 1'b0;
        iFLUSH = 1'b0;
        iREADY = 1'b1;
        repeat (4) @(posedge iCLK);
        #1;
        @(negedge iCLK);
        check("drain", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage_pipe.md
Name: decode_stage_pipe

Overview:
- Parametrised, elastic successor of the single-register decode stage. It sits between fetch and execute.
- Extracts opcode, register indices, immediate and src2-select fields from an instruction word, with configurable field widths.
- Forwards decoded fields through a 2-entry skid buffer with valid/ready handshakes on both sides, plus flush and a retired-decode counter.
- Fetch can keep streaming while execute stalls, without dropping or duplicating instructions.

Parameters:
- INSN_W, 16, instruction word width
- OP_W, 4, opcode field width
- IDX_W, 2, register index width (register file has 2^IDX_W entries)
- IMM_W, 8, immediate field width in the instruction
- DATA_W, 8, width of oIMM_VAL; must be >= IMM_W
- IMM_SEXT, 0, 1 = sign-extend the immediate to DATA_W; 0 = zero-extend
- CNT_W, 16, width of the decode counter

Ports:
- iCLK  in  1  clock; all state updates on posedge
- iRST  in  1  asynchronous, active-low reset
- iVALID  in  1  upstream instruction valid
- oREADY  out  1  stage can accept an instruction this cycle
- iINSTRUCTION  in  INSN_W  instruction word
- iFLUSH  in  1  discard all buffered instructions
- oVALID  out  1  decoded bundle valid
- iREADY  in  1  downstream accepts the bundle
- oEXE_OP  out  OP_W  opcode
- oIN1_IDX  out  IDX_W  source 1 register index
- oIN2_IDX  out  IDX_W  source 2 register index
- oDST_IDX  out  IDX_W  destination register index
- oIMM_VAL  out  DATA_W  extended immediate
- oSRC2_IS_REG_OR_IMM  out  1  1 = src2 is the immediate, 0 = src2 is the register
- oDEC_CNT  out  CNT_W  count of bundles handed downstream
- oILLEGAL  out  1  see Optional Feature; tied 0 when the feature is compiled out

Behaviour:
- Field map, MSB first:
  - opcode = iINSTRUCTION[INSN_W-1 -: OP_W]
  - dst = next IDX_W bits below the opcode
  - in1 = next IDX_W bits below dst
  - in2 = next IDX_W bits below in1
  - imm = iINSTRUCTION[IMM_W-1:0]; this field may overlap in2
  - src2 select = opcode MSB
- With the defaults: [15:12] op, [11:10] dst, [9:8] in1, [7:6] in2, [7:0] imm.
- Immediate extension: per IMM_SEXT; when DATA_W == IMM_W the field passes through unchanged.
- Decode is combinational on the input side. Only registered values drive outputs; no combinational path from iINSTRUCTION, iVALID or iREADY to any output.
- Handshakes:
  - Input transfer occurs when iVALID && oREADY.
  - Output transfer occurs when oVALID && iREADY.
  - oREADY = skid buffer empty (registered).
  - While oVALID is high and iREADY is low, output fields hold stable.
- States (main register M, skid register S):
  - EMPTY (M and S invalid): an input transfer loads M -> BUSY.
  - BUSY (M valid, S invalid):
    - in and out together: M reloads, stays BUSY.
    - out only -> EMPTY.
    - in only (downstream stalled): loads S -> FULL.
  - FULL (M and S valid, oREADY=0):
    - out transfer: S moves to M -> BUSY.
    - no out transfer: hold.
- Latency: 1 cycle from input transfer to oVALID when in EMPTY. Throughput: 1 bundle per cycle.
- Ordering: strictly FIFO; no instruction is dropped or duplicated except by flush.
- Flush: iFLUSH high at a posedge -> M and S both invalid -> EMPTY next cycle.
  - Flush takes priority over any same-cycle input transfer; that instruction is discarded.
  - A same-cycle output transfer still counts in oDEC_CNT.
  - oREADY is 1 in the cycle after a flush.
- Counter: oDEC_CNT increments by 1 per output transfer and wraps modulo 2^CNT_W. It is not cleared by flush.
- Reset (iRST=0, asynchronous, at any time including mid-stall): state EMPTY; oVALID=0; oREADY=1 after release; all field outputs 0; oDEC_CNT=0; oILLEGAL=0.
- Invalid slots: field outputs hold their last value when oVALID=0 and are don't-care for downstream.

Optional Feature:
- Macro: DECODE_ILLEGAL_CHECK_EN.
- Defined:
  - Adds parameter NUM_OPS, default 12.
  - An opcode >= NUM_OPS is illegal. It is accepted and forwarded with oILLEGAL=1 registered alongside its bundle; downstream treats it as a trap.
  - oILLEGAL follows the bundle through the skid buffer and is cleared by reset and flush.
- Undefined: no check is performed; oILLEGAL is constant 0.

Test Plan:
- Reset then one transfer of 16'hA5C3 with iREADY=1 -> next cycle oVALID=1:
  - oEXE_OP=4'hA, oDST_IDX=1, oIN1_IDX=1, oIN2_IDX=3
  - oIMM_VAL=8'hC3, oSRC2_IS_REG_OR_IMM=1
  - oDEC_CNT becomes 1 after the output transfer.
- Back-pressure: stream 16'h1000, 16'h2000, 16'h3000 with iREADY=0 -> oREADY drops to 0 after the second transfer, the third word is held upstream, oEXE_OP stays 1. Then raise iREADY -> outputs 1, 2, 3 in order, with no gaps once flowing.
- Sign extension: IMM_W=4, DATA_W=8, IMM_SEXT=1, instruction with imm 4'b1010 -> oIMM_VAL=8'hFA. With IMM_SEXT=0 -> 8'h0A.
- Flush in FULL with iVALID=1 -> next cycle oVALID=0, oREADY=1, the flushed-cycle input never appears at the output, and oDEC_CNT is unchanged.
- Asynchronous reset asserted mid-cycle while FULL -> outputs clear immediately without waiting for a clock edge. After release, a new instruction decodes with 1-cycle latency.
- CNT_W=4, 17 output transfers -> oDEC_CNT wraps to 1. With DECODE_ILLEGAL_CHECK_EN and NUM_OPS=12, opcode 4'hD -> oILLEGAL=1 and opcode 4'h3 -> oILLEGAL=0.
